key_counter: RTL and testbench

//  Upstream value source for the 2-digit BCD display stage: debounces two DE2 pushbuttons
//  (active-low KEY inputs), turns each clean press into a one-cycle event and keeps a
//  4-bit up/down count 0..15. Its count drives the display stage's 4-bit SW input

---
 rtl/key_pkg.sv | 23 ++
 rtl/key_debounce.sv | 158 +++++++++++++++
 rtl/key_counter.sv | 84 ++++++++
 tb/tb_key_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, widths and sizing helper for the key counter
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } debounce_state_t;

    localparam int COUNT_W = 4;

    // Smallest register width able to hold the values 0 .. n-1 (never below one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one pushbutton: 2-flop sync, debounce FSM, press pulse; auto-repeat under AUTO_REPEAT_EN
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int                TMR_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    debounce_state_t r_state;
    debounce_state_t w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic            r_pulse;
    logic            w_press_evt;
    logic            w_enter_pressed;
    logic            w_repeat_evt;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM state, timer and the registered one-cycle press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RELEASED;
            r_timer <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_pulse <= w_press_evt | w_repeat_evt;
        end
    end

    // Next-state logic: a level change must hold DEBOUNCE_CYCLES further samples to be accepted.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_press_evt     = 1'b0;
        w_enter_pressed = 1'b0;
        case (r_state)
            RELEASED: begin
                if (!r_sync2) begin
                    w_state_nxt = PRESS_PEND;
                    w_timer_nxt = '0;
                end
            end
            PRESS_PEND: begin
                if (r_sync2) begin
                    w_state_nxt = RELEASED;
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt     = PRESSED;
                    w_press_evt     = 1'b1;
                    w_enter_pressed = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            PRESSED: begin
                if (r_sync2) begin
                    w_state_nxt = RELEASE_PEND;
                    w_timer_nxt = '0;
                end
            end
            RELEASE_PEND: begin
                if (!r_sync2) begin
                    w_state_nxt     = PRESSED;
                    w_enter_pressed = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt = RELEASED;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_timer_nxt = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_armed;
    logic              w_armed_nxt;

    // Hold timer register; r_armed marks that the first (longer) delay has elapsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_hold  <= w_hold_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // Repeat scheduling: counts only while stably PRESSED, restarts on every entry to PRESSED.
    always_comb begin
        w_hold_nxt   = r_hold;
        w_armed_nxt  = r_armed;
        w_repeat_evt = 1'b0;
        if (w_enter_pressed) begin
            w_hold_nxt  = '0;
            w_armed_nxt = 1'b0;
        end else if ((r_state == PRESSED) && !r_sync2) begin
            if (!r_armed) begin
                if (r_hold == DELAY_LAST) begin
                    w_repeat_evt = 1'b1;
                    w_hold_nxt   = '0;
                    w_armed_nxt  = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end else if (r_hold == PERIOD_LAST) begin
                w_repeat_evt = 1'b1;
                w_hold_nxt   = '0;
            end else begin
                w_hold_nxt = r_hold + 1'b1;
            end
        end
    end
`else
    assign w_repeat_evt = 1'b0;
`endif

    assign pressed     = (r_state == PRESSED) || (r_state == RELEASE_PEND);
    assign press_pulse = r_pulse;

endmodule

// File: rtl/key_counter.sv
// rtl/key_counter.sv - two debounced keys driving a 4-bit wrap up/down count; auto-repeat under AUTO_REPEAT_EN
module key_counter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               KEY_up,
    input  logic               KEY_down,
    output logic [COUNT_W-1:0] count,
    output logic               changed,
    output logic [1:0]         LEDG
);

    logic               w_up_pressed;
    logic               w_up_pulse;
    logic               w_down_pressed;
    logic               w_down_pulse;
    logic [COUNT_W-1:0] r_count;
    logic               r_changed;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_up (
        .clk        (CLOCK_50),
        .reset      (reset),
        .key_n      (KEY_up),
        .pressed    (w_up_pressed),
        .press_pulse(w_up_pulse)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_down (
        .clk        (CLOCK_50),
        .reset      (reset),
        .key_n      (KEY_down),
        .pressed    (w_down_pressed),
        .press_pulse(w_down_pulse)
    );

    // Wrap-around counter; simultaneous up and down pulses cancel and leave changed low.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_count   <= '0;
            r_changed <= 1'b0;
        end else begin
            case ({w_up_pulse, w_down_pulse})
                2'b10: begin
                    r_count   <= r_count + 1'b1;
                    r_changed <= 1'b1;
                end
                2'b01: begin
                    r_count   <= r_count - 1'b1;
                    r_changed <= 1'b1;
                end
                default: begin
                    r_changed <= 1'b0;
                end
            endcase
        end
    end

    assign count   = r_count;
    assign changed = r_changed;
    assign LEDG    = {w_down_pressed, w_up_pressed};

endmodule

// File: tb/tb_key_counter.sv
// tb/tb_key_counter.sv - scoreboard bench for key_counter against a run-length debounce model
module tb_key_counter;

    localparam int D  = 4;
`ifdef AUTO_REPEAT_EN
    localparam int RD = 20;
    localparam int RP = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       KEY_up;
    logic       KEY_down;
    logic [3:0] count;
    logic       changed;
    logic [1:0] LEDG;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_counter #(
        .DEBOUNCE_CYCLES(D)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .KEY_up  (KEY_up),
        .KEY_down(KEY_down),
        .count   (count),
        .changed (changed),
        .LEDG    (LEDG)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a key level is accepted once the synchronized sample has differed
    // from the accepted level for D+1 consecutive edges; acceptance of "pressed" is an event.
    int  m_cnt;
    bit  m_pu, m_pd;
    bit  m_deb  [2];
    int  m_run  [2];
    int  m_hold [2];
    bit  m_k1   [2];
    bit  m_k2   [2];
    bit  m_pulse[2];
    bit  m_raw  [2];
    bit  m_lvl;
    int  exp_q[$];

    always @(posedge clk) begin
        m_raw[0] = KEY_up;
        m_raw[1] = KEY_down;
        if (reset) begin
            m_cnt = 0;
            m_pu  = 0;
            m_pd  = 0;
            for (int i = 0; i < 2; i++) begin
                m_deb[i]  = 0;
                m_run[i]  = 0;
                m_hold[i] = 0;
                m_k1[i]   = 1;
                m_k2[i]   = 1;
            end
        end else begin
            if (m_pu != m_pd) begin
                m_cnt = m_pu ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
                exp_q.push_back(m_cnt);
            end
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = 0;
                m_lvl = !m_k2[i];
                if (m_lvl != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_deb[i]   = m_lvl;
                        m_run[i]   = 0;
                        m_hold[i]  = 0;
                        m_pulse[i] = m_lvl;
                    end
                end else begin
                    if (m_deb[i] && m_run[i] != 0) begin
                        m_hold[i] = 0;
                    end else if (m_deb[i]) begin
                        m_hold[i]++;
`ifdef AUTO_REPEAT_EN
                        if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) m_pulse[i] = 1;
`endif
                    end
                    m_run[i] = 0;
                end
                m_k2[i] = m_k1[i];
                m_k1[i] = m_raw[i];
            end
            m_pu = m_pulse[0];
            m_pd = m_pulse[1];
        end
    end

    // Monitor: compares levels every cycle and pops one expected count per changed pulse.
    always @(negedge clk) begin
        check("ledg", LEDG, {m_deb[1], m_deb[0]});
        check("count_track", count, m_cnt);
        if (changed) begin
            if (exp_q.size() == 0) check("changed_unexpected", changed, 0);
            else check("changed_count", count, exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
            check("changed_missing", changed, 1);
            exp_q.delete();
        end
    end

    task automatic step(input bit u, input bit d, input int n);
        KEY_up   = u;
        KEY_down = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit u, input bit d, input int hold);
        step(!u, !d, hold);
        step(1'b1, 1'b1, D + 6);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int lat;

    initial begin
        reset    = 1'b1;
        KEY_up   = 1'b1;
        KEY_down = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        step(1, 1, 10);
        check("idle_count", count, 0);
        check("idle_ledg", LEDG, 0);

        KEY_up = 1'b0;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (changed) begin
                lat = i;
                break;
            end
        end
        check("press_latency", lat, D + 3);
        check("press_ledg_up", LEDG, 1);
        repeat (4) @(negedge clk);
        step(1, 1, D + 6);
        check("single_press", count, 1);

        step(1, 1, 2); step(0, 1, 2); step(1, 1, 2); step(0, 1, 12);
        step(1, 1, D + 6);
        check("bounce_press", count, 2);

        do_reset();
        for (int i = 0; i < 15; i++) press(1, 0, 8);
        check("wrap_15", count, 15);
        press(1, 0, 8);
        check("wrap_0", count, 0);
        press(0, 1, 8);
        check("wrap_back_15", count, 15);

        step(0, 0, 10);
        check("both_ledg", LEDG, 3);
        step(1, 1, D + 6);
        check("both_count", count, 15);

        do_reset();
        for (int i = 0; i < 5; i++) press(1, 0, 8);
        check("pre_reset_5", count, 5);
        step(0, 1, 4);
        do_reset();
        check("reset_mid_pend", count, 0);
        step(0, 1, 12);
        check("relatch_after_reset", count, 1);
        step(1, 1, D + 6);

`ifdef AUTO_REPEAT_EN
        do_reset();
        step(0, 1, 60);
        step(1, 1, D + 6);
        check("auto_repeat", count, 6);
`endif

        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 15));
        end
        step(1, 1, 20);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
